// File: rtl/phoenix_wait_state_memory.sv
// phoenix_wait_state_memory: dual-port wait-state memory model with console and exit registers
module phoenix_wait_state_memory #(
    parameter int          DEPTH_WORDS     = 8388608,
    parameter string       INIT_FILE       = "firmware.hex",
    parameter int          IMEM_LATENCY    = 0,
    parameter int          DMEM_LATENCY    = 0,
    parameter logic [31:0] CONSOLE_ADDRESS = 32'h1000_0000,
    parameter logic [31:0] EXIT_ADDRESS    = 32'h1000_0004
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instruction_memory_interface_enable,
    input  logic [31:0] instruction_memory_interface_address,
    output logic [31:0] instruction_memory_interface_data,
    output logic        instruction_memory_interface_ready,
    input  logic        data_memory_interface_enable,
    input  logic        data_memory_interface_state,
    input  logic [31:0] data_memory_interface_address,
    input  logic [3:0]  data_memory_interface_frame_mask,
    input  logic [31:0] data_memory_interface_write_data,
    output logic [31:0] data_memory_interface_read_data,
    output logic        data_memory_interface_ready,
    output logic        console_valid,
    output logic [7:0]  console_data,
    output logic        halted,
    output logic [31:0] exit_code,
    output logic        address_error
);
    localparam int          AW    = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] DEPTH = 32'(DEPTH_WORDS);
    localparam logic [3:0]  I_LAT = 4'(IMEM_LATENCY);
    localparam logic [3:0]  D_LAT = 4'(DMEM_LATENCY);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    logic [31:0] mem [DEPTH_WORDS];

    state_t      i_st, d_st;
    logic [3:0]  i_cnt, d_cnt;
    logic [29:0] i_word_q, d_word_q, i_word, d_word;
    logic        d_we_q, d_we;
    logic [3:0]  d_mask_q, d_mask;
    logic [31:0] d_wdata_q, d_wdata;
    logic        i_fire, d_fire, i_mmio, d_con, d_exit, i_err, d_err, i_ok, d_ok;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^{instruction_memory_interface_address[1:0], data_memory_interface_address[1:0]};

    // Live request fields while idle, captured fields once an access is in flight
    always_comb begin
        i_word  = i_st == IDLE ? instruction_memory_interface_address[31:2] : i_word_q;
        d_word  = d_st == IDLE ? data_memory_interface_address[31:2] : d_word_q;
        d_we    = d_st == IDLE ? data_memory_interface_state : d_we_q;
        d_mask  = d_st == IDLE ? data_memory_interface_frame_mask : d_mask_q;
        d_wdata = d_st == IDLE ? data_memory_interface_write_data : d_wdata_q;
        i_fire  = (i_st == IDLE && instruction_memory_interface_enable && I_LAT == 4'd0) || (i_st == WAIT && i_cnt == 4'd1);
        d_fire  = (d_st == IDLE && data_memory_interface_enable && D_LAT == 4'd0) || (d_st == WAIT && d_cnt == 4'd1);
        i_mmio  = i_word == CONSOLE_ADDRESS[31:2] || i_word == EXIT_ADDRESS[31:2];
        d_con   = d_word == CONSOLE_ADDRESS[31:2];
        d_exit  = d_word == EXIT_ADDRESS[31:2];
        i_err   = !i_mmio && {2'b00, i_word} >= DEPTH;
        d_err   = !(d_con || d_exit) && {2'b00, d_word} >= DEPTH;
        i_ok    = !i_mmio && !i_err;
        d_ok    = !(d_con || d_exit) && !d_err;
    end

    // Instruction port FSM; fetch data is sampled on the edge entering RESP
    always_ff @(posedge clk) begin
        if (reset) begin
            i_st                               <= IDLE;
            i_cnt                              <= '0;
            i_word_q                           <= '0;
            instruction_memory_interface_ready <= 1'b0;
            instruction_memory_interface_data  <= '0;
        end else begin
            instruction_memory_interface_ready <= i_fire;
            if (i_fire) instruction_memory_interface_data <= i_ok ? mem[i_word[AW-1:0]] : '0;
            case (i_st)
                IDLE: if (instruction_memory_interface_enable) begin
                    i_word_q <= i_word;
                    i_cnt    <= I_LAT;
                    i_st     <= I_LAT == 4'd0 ? RESP : WAIT;
                end
                WAIT: begin
                    i_cnt <= i_cnt - 4'd1;
                    if (i_cnt == 4'd1) i_st <= RESP;
                end
                default: i_st <= IDLE;
            endcase
        end
    end

    // Data port FSM; load data is sampled on the edge entering RESP
    always_ff @(posedge clk) begin
        if (reset) begin
            d_st                            <= IDLE;
            d_cnt                           <= '0;
            d_word_q                        <= '0;
            d_we_q                          <= 1'b0;
            d_mask_q                        <= '0;
            d_wdata_q                       <= '0;
            data_memory_interface_ready     <= 1'b0;
            data_memory_interface_read_data <= '0;
        end else begin
            data_memory_interface_ready <= d_fire;
            if (d_fire && !d_we) data_memory_interface_read_data <= d_ok ? mem[d_word[AW-1:0]] : '0;
            case (d_st)
                IDLE: if (data_memory_interface_enable) begin
                    d_word_q  <= d_word;
                    d_we_q    <= d_we;
                    d_mask_q  <= d_mask;
                    d_wdata_q <= d_wdata;
                    d_cnt     <= D_LAT;
                    d_st      <= D_LAT == 4'd0 ? RESP : WAIT;
                end
                WAIT: begin
                    d_cnt <= d_cnt - 4'd1;
                    if (d_cnt == 4'd1) d_st <= RESP;
                end
                default: d_st <= IDLE;
            endcase
        end
    end

    // Byte-masked store into the array, committed on the edge entering RESP
    always_ff @(posedge clk) begin
        if (!reset && d_fire && d_we && d_ok)
            for (int b = 0; b < 4; b++)
                if (d_mask[3-b]) mem[d_word[AW-1:0]][8*b +: 8] <= d_wdata[8*b +: 8];
    end

    // Console, exit and address-error status aligned with the RESP cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            console_valid <= 1'b0;
            console_data  <= '0;
            halted        <= 1'b0;
            exit_code     <= '0;
            address_error <= 1'b0;
        end else begin
            console_valid <= d_fire && d_we && d_con;
            address_error <= (i_fire && i_err) || (d_fire && d_err);
            if (d_fire && d_we && d_con) console_data <= d_wdata[7:0];
            if (d_fire && d_we && d_exit) begin
                halted    <= 1'b1;
                exit_code <= d_wdata;
            end
        end
    end
endmodule

// File: tb/tb_phoenix_wait_state_memory.sv
// tb_phoenix_wait_state_memory: directed table-driven bench for the wait-state memory model
module tb_phoenix_wait_state_memory;
    localparam logic [31:0] CON = 32'h1000_0000;
    localparam logic [31:0] EXT = 32'h1000_0004;
    localparam int IL = 1;
    localparam int DL = 3;
    localparam int NV = 19;

    typedef struct {
        logic        p;
        logic        we;
        logic [31:0] a;
        logic [3:0]  m;
        logic [31:0] wd;
        logic [31:0] exp;
        logic        err;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ien = 1'b0;
    logic [31:0] iaddr = '0;
    logic [31:0] idata;
    logic        irdy;
    logic        den = 1'b0;
    logic        dwe = 1'b0;
    logic [31:0] daddr = '0;
    logic [3:0]  dmask = '0;
    logic [31:0] dwd = '0;
    logic [31:0] drd;
    logic        drdy;
    logic        cvalid;
    logic [7:0]  cdata;
    logic        halted;
    logic [31:0] exit_code;
    logic        aerr;
    int          checks = 0;
    int          errors = 0;
    vec_t        tbl [NV];

    always #5 clk = ~clk;

    phoenix_wait_state_memory #(
        .DEPTH_WORDS(16),
        .INIT_FILE(""),
        .IMEM_LATENCY(IL),
        .DMEM_LATENCY(DL),
        .CONSOLE_ADDRESS(CON),
        .EXIT_ADDRESS(EXT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .instruction_memory_interface_enable(ien),
        .instruction_memory_interface_address(iaddr),
        .instruction_memory_interface_data(idata),
        .instruction_memory_interface_ready(irdy),
        .data_memory_interface_enable(den),
        .data_memory_interface_state(dwe),
        .data_memory_interface_address(daddr),
        .data_memory_interface_frame_mask(dmask),
        .data_memory_interface_write_data(dwd),
        .data_memory_interface_read_data(drd),
        .data_memory_interface_ready(drdy),
        .console_valid(cvalid),
        .console_data(cdata),
        .halted(halted),
        .exit_code(exit_code),
        .address_error(aerr)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic access(input logic p, input logic we, input logic [31:0] a, input logic [3:0] m,
                          input logic [31:0] wd, output logic [31:0] rd, output logic er,
                          output int lat, output logic after);
        if (p) begin
            den = 1'b1; dwe = we; daddr = a; dmask = m; dwd = wd;
        end else begin
            ien = 1'b1; iaddr = a;
        end
        @(posedge clk); #1;
        den = 1'b0; ien = 1'b0;
        lat = -1; rd = '0; er = 1'b0;
        for (int k = 0; k <= 20; k++) begin
            if (p ? drdy : irdy) begin
                lat = k; rd = p ? drd : idata; er = aerr;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        after = p ? drdy : irdy;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic        er, after, co;
        int          lat, n;
        tbl = '{
            '{1'b1, 1'b1, 32'h10, 4'hF,    32'hDEADBEEF, 32'h0,        1'b0},
            '{1'b0, 1'b0, 32'h10, 4'h0,    32'h0,        32'hDEADBEEF, 1'b0},
            '{1'b1, 1'b1, 32'h08, 4'hF,    32'h0,        32'h0,        1'b0},
            '{1'b1, 1'b1, 32'h08, 4'b1001, 32'h11223344, 32'h0,        1'b0},
            '{1'b1, 1'b0, 32'h08, 4'h0,    32'h0,        32'h11000044, 1'b0},
            '{1'b1, 1'b1, 32'h0A, 4'b0110, 32'hAABBCCDD, 32'h0,        1'b0},
            '{1'b1, 1'b0, 32'h0B, 4'h0,    32'h0,        32'h11BBCC44, 1'b0},
            '{1'b1, 1'b1, 32'h08, 4'b0000, 32'hFFFFFFFF, 32'h0,        1'b0},
            '{1'b1, 1'b0, 32'h08, 4'h0,    32'h0,        32'h11BBCC44, 1'b0},
            '{1'b0, 1'b0, 32'h09, 4'h0,    32'h0,        32'h11BBCC44, 1'b0},
            '{1'b1, 1'b1, 32'h00, 4'hF,    32'h55667788, 32'h0,        1'b0},
            '{1'b1, 1'b1, 32'h40, 4'hF,    32'hFFFFFFFF, 32'h0,        1'b1},
            '{1'b1, 1'b0, 32'h00, 4'h0,    32'h0,        32'h55667788, 1'b0},
            '{1'b1, 1'b0, 32'h40, 4'h0,    32'h0,        32'h0,        1'b1},
            '{1'b0, 1'b0, 32'h44, 4'h0,    32'h0,        32'h0,        1'b1},
            '{1'b1, 1'b1, 32'h20, 4'hF,    32'hAAAA5555, 32'h0,        1'b0},
            '{1'b1, 1'b0, 32'h20, 4'h0,    32'h0,        32'hAAAA5555, 1'b0},
            '{1'b1, 1'b0, CON,    4'h0,    32'h0,        32'h0,        1'b0},
            '{1'b1, 1'b0, EXT,    4'h0,    32'h0,        32'h0,        1'b0}
        };
        repeat (3) @(posedge clk);
        #1;
        chk("rst_irdy", 32'(irdy), 32'd0);
        chk("rst_drdy", 32'(drdy), 32'd0);
        chk("rst_idata", idata, 32'd0);
        chk("rst_drd", drd, 32'd0);
        chk("rst_cvalid", 32'(cvalid), 32'd0);
        chk("rst_cdata", 32'(cdata), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_exit", exit_code, 32'd0);
        chk("rst_aerr", 32'(aerr), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            access(tbl[i].p, tbl[i].we, tbl[i].a, tbl[i].m, tbl[i].wd, rd, er, lat, after);
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'(tbl[i].p ? DL : IL));
            chk($sformatf("v%0d_addr_error", i), 32'(er), 32'(tbl[i].err));
            chk($sformatf("v%0d_ready_pulse", i), 32'(after), 32'd0);
            if (!tbl[i].we) chk($sformatf("v%0d_data", i), rd, tbl[i].exp);
        end

        den = 1'b1; dwe = 1'b1; daddr = CON; dmask = 4'hF; dwd = 32'h41;
        @(posedge clk); #1;
        den = 1'b0;
        n = 0; co = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (cvalid) begin
                n++;
                if (!drdy) co = 1'b0;
            end
            @(posedge clk); #1;
        end
        chk("console_pulses", 32'(n), 32'd1);
        chk("console_with_ready", 32'(co), 32'd1);
        chk("console_data", 32'(cdata), 32'h41);

        chk("halted_before_exit", 32'(halted), 32'd0);
        access(1'b1, 1'b1, EXT, 4'hF, 32'd7, rd, er, lat, after);
        chk("exit_latency", 32'(lat), 32'(DL));
        chk("exit_halted", 32'(halted), 32'd1);
        chk("exit_code", exit_code, 32'd7);
        repeat (5) @(posedge clk);
        #1;
        chk("exit_halted_held", 32'(halted), 32'd1);
        chk("exit_code_held", exit_code, 32'd7);

        den = 1'b1; dwe = 1'b1; daddr = 32'h20; dmask = 4'hF; dwd = 32'h12345678;
        @(posedge clk); #1;
        den = 1'b0;
        n = 0;
        @(posedge clk); #1;
        n += int'(drdy);
        @(posedge clk); #1;
        n += int'(drdy);
        reset = 1'b1;
        @(posedge clk); #1;
        n += int'(drdy);
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            n += int'(drdy);
        end
        chk("reset_wait_no_ready", 32'(n), 32'd0);
        chk("reset_halted_clear", 32'(halted), 32'd0);
        chk("reset_exit_clear", exit_code, 32'd0);
        chk("reset_cdata_clear", 32'(cdata), 32'd0);
        chk("reset_drd_clear", drd, 32'd0);
        access(1'b1, 1'b0, 32'h20, 4'h0, 32'h0, rd, er, lat, after);
        chk("reset_new_latency", 32'(lat), 32'(DL));
        chk("reset_write_dropped", rd, 32'hAAAA5555);

        den = 1'b1; dwe = 1'b1; daddr = 32'h0; dmask = 4'hF; dwd = 32'hCAFEF00D;
        @(posedge clk); #1;
        den = 1'b0;
        @(posedge clk); #1;
        ien = 1'b1; iaddr = 32'h0;
        @(posedge clk); #1;
        ien = 1'b0;
        @(posedge clk); #1;
        chk("collide_iready", 32'(irdy), 32'd1);
        chk("collide_dready", 32'(drdy), 32'd1);
        chk("collide_old_value", idata, 32'h55667788);
        @(posedge clk); #1;
        access(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, rd, er, lat, after);
        chk("collide_new_latency", 32'(lat), 32'(IL));
        chk("collide_new_value", rd, 32'hCAFEF00D);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
